// File: rtl/fdiv_pkg.sv
// Shared constants and helpers for the programmable clock-enable divider.
// fdiv_decode is the single definition of the output waveform shape.
package fdiv_pkg;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  // Operands are carried at 32 bits so one function serves any W up to 31.
  function automatic logic [31:0] clamp_div(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

  function automatic logic fdiv_decode(input logic [31:0] cnt, input logic [31:0] div,
                                       input logic mode);
    logic [32:0] half;
    half = ({1'b0, div} + 33'd1) >> 1;
    if (mode == MODE_PULSE) begin
      return cnt == 32'd0;
    end
    return {1'b0, cnt} < half;
  endfunction

endpackage

// File: rtl/fdiv_prog.sv
// Runtime-programmable clock-enable divider: counts enabled cycles modulo a shadowed divisor
// and produces a registered pulse/square output plus a combinational wrap tick.
module fdiv_prog
  import fdiv_pkg::*;
#(
  parameter int unsigned W           = 8,
  parameter int unsigned DIV_DEFAULT = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         c_up,
  input  logic [W-1:0] div,
  input  logic         mode,
  output logic         fdclk,
  output logic         tick,
  output logic [W-1:0] cnt,
  output logic [W-1:0] div_active
);

  localparam logic [W-1:0] One      = W'(1);
  localparam logic [W-1:0] DivReset = (DIV_DEFAULT == 0) ? One : W'(DIV_DEFAULT);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic         fdclk_q;
  logic         wrap;
  logic [W-1:0] div_req;

  assign div_req = W'(clamp_div(32'(div)));
  assign wrap    = (cnt_q == div_q - One);

  // The divisor is only sampled at period boundaries so a period never gets cut short.
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (clr) begin
      cnt_d = '0;
      div_d = div_req;
    end else if (c_up) begin
      if (wrap) begin
        cnt_d = '0;
        div_d = div_req;
      end else begin
        cnt_d = cnt_q + One;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= DivReset;
      fdclk_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      fdclk_q <= fdiv_decode(32'(cnt_d), 32'(div_d), mode);
    end
  end

  assign tick       = c_up & ~clr & ~rst & wrap;
  assign fdclk      = fdclk_q;
  assign cnt        = cnt_q;
  assign div_active = div_q;

endmodule

// File: tb/tb_fdiv_prog.sv
// Directed bench for fdiv_prog: each stimulus step queues its hand-computed expected outputs,
// and a negedge monitor pops and compares them independently of the driver.
module tb_fdiv_prog;

  logic       clk = 1'b0;
  logic       rst, clr, c_up, mode;
  logic [7:0] div;
  logic       fdclk, tick;
  logic [7:0] cnt, div_active;

  typedef struct packed {
    int         id;
    logic [7:0] cnt;
    logic [7:0] div;
    logic       fd;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_id = 0;

  fdiv_prog #(
    .W          (8),
    .DIV_DEFAULT(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .c_up      (c_up),
    .div       (div),
    .mode      (mode),
    .fdclk     (fdclk),
    .tick      (tick),
    .cnt       (cnt),
    .div_active(div_active)
  );

  always #5 clk = ~clk;

  // Apply inputs for one cycle and queue what the outputs must show during that cycle.
  task automatic step(input logic r, input logic cl, input logic cu, input logic [7:0] d,
                      input logic m, input logic [7:0] e_cnt, input logic [7:0] e_div,
                      input logic e_fd, input logic e_tick);
    exp_t e;
    rst  = r;
    clr  = cl;
    c_up = cu;
    div  = d;
    mode = m;
    e.id   = step_id;
    e.cnt  = e_cnt;
    e.div  = e_div;
    e.fd   = e_fd;
    e.tick = e_tick;
    exp_q.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if ({cnt, div_active, fdclk, tick} !== {e.cnt, e.div, e.fd, e.tick}) begin
        n_fail++;
        $display("FAIL step%0d: got cnt=%0d div_active=%0d fdclk=%b tick=%b, want cnt=%0d div_active=%0d fdclk=%b tick=%b",
                 e.id, cnt, div_active, fdclk, tick, e.cnt, e.div, e.fd, e.tick);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; c_up = 1'b0; div = 8'd5; mode = 1'b0;
    @(posedge clk);
    #1;
    //   rst clr cu div    m    cnt  div  fd  tick
    // Reset state, tick suppressed while rst is high.
    step(1, 0, 0, 8'd5, 0, 8'd0, 8'd5, 1, 0);
    step(1, 0, 1, 8'd5, 0, 8'd0, 8'd5, 1, 0);
    // Default divide-by-5, pulse mode.
    step(0, 0, 1, 8'd5, 0, 8'd0, 8'd5, 1, 0);
    step(0, 0, 1, 8'd5, 0, 8'd1, 8'd5, 0, 0);
    step(0, 0, 1, 8'd5, 0, 8'd2, 8'd5, 0, 0);
    step(0, 0, 1, 8'd5, 0, 8'd3, 8'd5, 0, 0);
    step(0, 0, 1, 8'd5, 0, 8'd4, 8'd5, 0, 1);
    step(0, 0, 1, 8'd5, 0, 8'd0, 8'd5, 1, 0);
    step(0, 0, 1, 8'd5, 0, 8'd1, 8'd5, 0, 0);
    // Divisor 3 requested at cnt 2: current period finishes at 5.
    step(0, 0, 1, 8'd3, 0, 8'd2, 8'd5, 0, 0);
    step(0, 0, 1, 8'd3, 0, 8'd3, 8'd5, 0, 0);
    step(0, 0, 1, 8'd3, 0, 8'd4, 8'd5, 0, 1);
    step(0, 0, 1, 8'd3, 0, 8'd0, 8'd3, 1, 0);
    step(0, 0, 1, 8'd3, 0, 8'd1, 8'd3, 0, 0);
    step(0, 0, 1, 8'd3, 0, 8'd2, 8'd3, 0, 1);
    step(0, 0, 1, 8'd3, 0, 8'd0, 8'd3, 1, 0);
    // Clear into square mode with divisor 6.
    step(0, 1, 1, 8'd6, 1, 8'd1, 8'd3, 0, 0);
    step(0, 0, 1, 8'd6, 1, 8'd0, 8'd6, 1, 0);
    step(0, 0, 1, 8'd6, 1, 8'd1, 8'd6, 1, 0);
    step(0, 0, 1, 8'd6, 1, 8'd2, 8'd6, 1, 0);
    step(0, 0, 1, 8'd6, 1, 8'd3, 8'd6, 0, 0);
    step(0, 0, 1, 8'd6, 1, 8'd4, 8'd6, 0, 0);
    step(0, 0, 1, 8'd5, 1, 8'd5, 8'd6, 0, 1);
    // Square mode, divisor 5: high for 0..2.
    step(0, 0, 1, 8'd5, 1, 8'd0, 8'd5, 1, 0);
    step(0, 0, 1, 8'd5, 1, 8'd1, 8'd5, 1, 0);
    step(0, 0, 1, 8'd5, 1, 8'd2, 8'd5, 1, 0);
    step(0, 0, 1, 8'd5, 1, 8'd3, 8'd5, 0, 0);
    step(0, 0, 1, 8'd5, 1, 8'd4, 8'd5, 0, 1);
    // Enable gating 1,0,1,0, then a mode change while holding.
    step(0, 0, 1, 8'd5, 1, 8'd0, 8'd5, 1, 0);
    step(0, 0, 0, 8'd5, 1, 8'd1, 8'd5, 1, 0);
    step(0, 0, 1, 8'd5, 1, 8'd1, 8'd5, 1, 0);
    step(0, 0, 0, 8'd5, 1, 8'd2, 8'd5, 1, 0);
    step(0, 0, 0, 8'd5, 0, 8'd2, 8'd5, 1, 0);
    step(0, 0, 1, 8'd5, 0, 8'd2, 8'd5, 0, 0);
    step(0, 0, 1, 8'd5, 0, 8'd3, 8'd5, 0, 0);
    // Clear with c_up at the wrap point: no tick, divisor 4 loaded.
    step(0, 1, 1, 8'd4, 0, 8'd4, 8'd5, 0, 0);
    step(0, 0, 1, 8'd4, 0, 8'd0, 8'd4, 1, 0);
    step(0, 0, 1, 8'd4, 0, 8'd1, 8'd4, 0, 0);
    step(0, 0, 1, 8'd4, 0, 8'd2, 8'd4, 0, 0);
    step(0, 0, 1, 8'd0, 0, 8'd3, 8'd4, 0, 1);
    // Divisor 0 clamps to 1: cnt stuck at 0, fdclk 1, tick follows c_up.
    step(0, 0, 1, 8'd0, 0, 8'd0, 8'd1, 1, 1);
    step(0, 0, 0, 8'd0, 0, 8'd0, 8'd1, 1, 0);
    step(0, 0, 1, 8'd0, 1, 8'd0, 8'd1, 1, 1);
    step(0, 0, 1, 8'd255, 1, 8'd0, 8'd1, 1, 1);
    // Divisor 255, square mode: high for 0..127, wrap at 254.
    for (int k = 0; k < 255; k++) begin
      step(0, 0, 1, 8'd5, 1, 8'(k), 8'd255, (k < 128), (k == 254));
    end
    // Reset mid-period with clr and c_up also high.
    step(0, 0, 1, 8'd7, 1, 8'd0, 8'd5, 1, 0);
    step(0, 0, 1, 8'd7, 1, 8'd1, 8'd5, 1, 0);
    step(0, 0, 1, 8'd7, 1, 8'd2, 8'd5, 1, 0);
    step(1, 1, 1, 8'd7, 1, 8'd3, 8'd5, 0, 0);
    step(0, 0, 1, 8'd7, 1, 8'd0, 8'd5, 1, 0);
    step(0, 0, 1, 8'd7, 1, 8'd1, 8'd5, 1, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fdiv_prog.md
Name: fdiv_prog

Overview:
- Runtime-programmable clock-enable divider, the next generation of the fixed divide-by-5 counter.
- Divides enabled cycles of clk by a programmable ratio DIV of 1..2^W-1.
- Produces a registered, glitch-free divided output in pulse or near-50% square mode, plus a one-cycle wrap tick.
- Used wherever lab designs need slow strobes (baud ticks, display refresh) from the single system clock.

Parameters:
- W, 8, width of the divisor and the counter.
- DIV_DEFAULT, 5, divisor loaded at reset; 0 is clamped to 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- clr  input  1  synchronous clear; restarts the period and reloads the divisor.
- c_up  input  1  count enable; the counter advances only when high.
- div  input  W  requested divisor; sampled only at reload points.
- mode  input  1  0 = pulse, 1 = square.
- fdclk  output  1  divided output, registered.
- tick  output  1  combinational wrap strobe: high when the counter wraps this cycle.
- cnt  output  W  current count, 0..div_active-1.
- div_active  output  W  divisor currently in use (shadow register).

Behaviour:
- Registers: cnt, div_active, fdclk. No other state.
- Clamp rule: clamp(x) = 1 if x == 0, else x. It applies to every load of div_active.
- Priority at each clk edge: rst > clr > c_up > hold.
- rst = 1: cnt <= 0; div_active <= clamp(DIV_DEFAULT); fdclk <= 1. Mid-operation reset aborts the period at the next edge; no partial state is kept.
- clr = 1: cnt <= 0; div_active <= clamp(div). This is unconditional, unlike the old divider's clear, which fired only when count >= 4.
- c_up = 1 with cnt == div_active-1 (wrap):
  - cnt <= 0;
  - div_active <= clamp(div).
  - New divisors therefore take effect only at period boundaries, which keeps the period glitch-free.
- c_up = 1 otherwise: cnt <= cnt+1; div_active holds.
- c_up = 0: all registers hold. Mode is still re-decoded (see the fdclk rule).
- tick = c_up & ~clr & ~rst & (cnt == div_active-1).
- fdclk rule: at every edge, fdclk is loaded with decode(cnt_next, div_active_next, mode), where mode is sampled at that edge. As a result, fdclk always equals decode(cnt, div_active) as seen on the outputs. A change on mode is reflected one edge later.
- Decode:
  - pulse mode: 1 iff cnt == 0;
  - square mode: 1 iff cnt < (div_active+1)>>1. High for ceil(N/2) counts, low for floor(N/2).
- div_active == 1: cnt stays 0. tick = c_up (gated as above). fdclk = 1 constant in both modes.
- div_active == 2^W-1: cnt reaches 2^W-2 and wraps to 0. No W-bit overflow is possible.
- div changes mid-period: ignored until the next wrap or clr. If div changes on the same edge as a wrap, the new value is loaded on that edge.
- clr and c_up together at the wrap point: clr wins; tick = 0; div is loaded.
- Width rules:
  - all compares are W-bit unsigned;
  - (div_active+1)>>1 is computed at W+1 bits so that 2^W-1 does not overflow.

Decomposition:
- Package fdiv_pkg holds:
  - MODE_PULSE = 1'b0 and MODE_SQUARE = 1'b1;
  - function clamp_div(W-bit) returning W bits;
  - function fdiv_decode(cnt, div, mode) returning 1 bit.
- No sub-module. Next-state logic and decode stay in fdiv_prog. fdiv_decode is shared through the package so the bench can use it as a reference model.

Test Plan:
- Reset default: rst high for 2 cycles, then c_up = 1, div = 5, mode = 0. Require cnt 0,1,2,3,4,0,...; fdclk high only when cnt = 0 (1 of every 5 cycles); tick high when cnt = 4; div_active = 5.
- Square mode: div = 6, mode = 1, clr pulsed once. Require fdclk high for cnt 0..2 and low for cnt 3..5. With div = 5: high for 0..2, low for 3..4.
- Divisor change mid-period: running with div_active = 5 at cnt = 2, set div = 3. Require cnt to continue 3,4 then wrap. div_active becomes 3 on the wrap edge, and the following periods are 0,1,2.
- Enable gating and clear: toggle c_up 1,0,1,0 and check cnt holds while c_up = 0 and tick stays 0. Assert clr at cnt = 4 together with c_up = 1. Require cnt = 0 and tick = 0 in that cycle, and div reloaded.
- Boundaries:
  - div = 0 → div_active = 1, fdclk stuck at 1, tick = c_up;
  - div = 255 (W = 8) → period 255, with fdclk high for cnt 0..127 in square mode.
- Mid-operation reset: assert rst at cnt = 3 with c_up and clr also high. Next edge: cnt = 0, div_active = 5, fdclk = 1. tick is 0 while rst is high.
